// File: rtl/seg7_bin_display.sv
`default_nettype none
// ============================================================================
// Module  : seg7_bin_display
// Purpose : Multi-digit 7-segment driver. Takes a binary value over a
//           valid/ready handshake, converts it to BCD with a sequential
//           double-dabble engine (or splits it into hex nibbles), and applies
//           leading-zero blanking, a minus sign and overflow indication.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           valid_in        - value_in and mode bits valid this cycle
//           ready_out       - block idle, can accept a value
//           value_in        - binary value (two's complement if signed_in)
//           signed_in       - treat value_in as signed (decimal only)
//           hex_mode        - 1 = hex nibbles, 0 = decimal
//           blank_lz        - 1 = blank leading zeros
//           segments        - digit i at [7i+6:7i], gfedcba, digit 0 rightmost
//           done            - one-cycle pulse after segments update
//           ovf             - last displayed value did not fit
// Revision: 1.0 - initial release
// ============================================================================
module seg7_bin_display #(
  parameter int DIGITS     = 6,
  parameter int BIN_W      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [BIN_W-1:0]      value_in,
  input  logic                  signed_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  done,
  output logic                  ovf
);

  // Decimal digits needed for 2^BIN_W-1: floor(BIN_W*log10(2)) + 1.
  localparam int c_NBCD = (BIN_W * 30103) / 100000 + 1;
  localparam int c_NHEX = BIN_W / 4;
  localparam int c_NSRC = (c_NBCD > c_NHEX) ? c_NBCD : c_NHEX;
  localparam int c_NALL = (c_NSRC > DIGITS) ? c_NSRC : DIGITS;
  localparam int c_CW   = $clog2(BIN_W);

  // Glyph table is stored lit-when-0; XOR with c_POL gives the output polarity.
  localparam logic [6:0] c_POL   = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic [6:0] c_BLANK = 7'h7F ^ c_POL;
  localparam logic [6:0] c_DASH  = 7'h3F ^ c_POL;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CONV = 2'd1;
  localparam logic [1:0] c_S_FMT  = 2'd2;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'h0: f_glyph = 7'h40;  4'h1: f_glyph = 7'h79;
      4'h2: f_glyph = 7'h24;  4'h3: f_glyph = 7'h30;
      4'h4: f_glyph = 7'h19;  4'h5: f_glyph = 7'h12;
      4'h6: f_glyph = 7'h02;  4'h7: f_glyph = 7'h78;
      4'h8: f_glyph = 7'h00;  4'h9: f_glyph = 7'h18;
      4'hA: f_glyph = 7'h08;  4'hB: f_glyph = 7'h03;
      4'hC: f_glyph = 7'h46;  4'hD: f_glyph = 7'h21;
      4'hE: f_glyph = 7'h06;  default: f_glyph = 7'h0E;
    endcase
  endfunction

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [BIN_W-1:0]        r_bin;
  logic [4*c_NBCD-1:0]     r_bcd;
  logic [c_CW-1:0]         r_cnt;
  logic                    r_neg;
  logic                    r_hex;
  logic                    r_blank;
  logic [7*DIGITS-1:0]     r_seg;
  logic                    r_done;
  logic                    r_ovf;

  logic                    w_take_neg;
  logic [BIN_W-1:0]        w_mag;
  logic [4*c_NBCD-1:0]     w_bcd_next;
  logic [3:0]              w_nib;
  logic [4*c_NALL-1:0]     w_src;
  logic [7:0]              w_n;
  logic [7:0]              w_req;
  logic                    w_ovf;
  logic [7*DIGITS-1:0]     w_seg_fmt;

  // Two's complement negate in BIN_W bits; the most negative value maps to
  // its own bit pattern, which read unsigned is exactly the right magnitude.
  assign w_take_neg = signed_in & ~hex_mode & value_in[BIN_W-1];
  assign w_mag      = w_take_neg ? ((~value_in) + BIN_W'(1)) : value_in;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (valid_in) w_next = hex_mode ? c_S_FMT : c_S_CONV;
      c_S_CONV: if (r_cnt == c_CW'(BIN_W - 1)) w_next = c_S_FMT;
      c_S_FMT:  w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready_out = (r_state == c_S_IDLE);
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift the magnitude MSB
  // in. The top bit shifted out of the BCD register is always zero because
  // the register is sized for the largest magnitude.
  always_comb begin
    w_bcd_next    = '0;
    w_nib         = '0;
    w_bcd_next[0] = r_bin[BIN_W-1];
    for (int i = 0; i < c_NBCD; i++) begin
      w_nib = r_bcd[4*i +: 4];
      if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
      for (int b = 0; b < 4; b++) begin
        if (4*i + b + 1 < 4*c_NBCD) w_bcd_next[4*i + b + 1] = w_nib[b];
      end
    end
  end

  // Digit source: BCD nibbles in decimal mode, raw nibbles in hex mode.
  always_comb begin
    w_src = '0;
    if (r_hex) w_src[BIN_W-1:0]      = r_bin;
    else       w_src[4*c_NBCD-1:0]   = r_bcd;
  end

  // Significant digit count, minimum one so that zero shows a single 0.
  always_comb begin
    w_n = 8'd1;
    for (int i = 0; i < c_NALL; i++) begin
      if (w_src[4*i +: 4] != 4'd0) w_n = 8'(i + 1);
    end
  end

  assign w_req = w_n + {7'd0, r_neg};
  assign w_ovf = (w_req > 8'(DIGITS));

  always_comb begin
    w_seg_fmt = '0;
    for (int p = 0; p < DIGITS; p++) begin
      if (w_ovf)
        w_seg_fmt[7*p +: 7] = c_DASH;
      else if (8'(p) < w_n)
        w_seg_fmt[7*p +: 7] = f_glyph(w_src[4*p +: 4]) ^ c_POL;
      else if (r_neg && ((r_blank && (8'(p) == w_n)) || (!r_blank && (p == DIGITS - 1))))
        w_seg_fmt[7*p +: 7] = c_DASH;
      else if (r_blank)
        w_seg_fmt[7*p +: 7] = c_BLANK;
      else
        w_seg_fmt[7*p +: 7] = f_glyph(4'h0) ^ c_POL;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_hex   <= 1'b0;
      r_blank <= 1'b0;
      r_seg   <= {DIGITS{c_BLANK}};
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (valid_in) begin
            r_bin   <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_neg   <= w_take_neg;
            r_hex   <= hex_mode;
            r_blank <= blank_lz;
          end
        end
        c_S_CONV: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + c_CW'(1);
        end
        c_S_FMT: begin
          r_seg  <= w_seg_fmt;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign segments = r_seg;
  assign done     = r_done;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bin_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_bin_display
// Purpose : Self-checking bench for seg7_bin_display. Two instances (6 and 4
//           digits) share one stimulus stream; results are compared against
//           a divide/modulo reference model and hand-derived patterns.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_bin_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] value_in;
  logic        signed_in;
  logic        hex_mode;
  logic        blank_lz;
  logic        ready6, done6, ovf6;
  logic [41:0] seg6;
  logic        ready4, done4, ovf4;
  logic [27:0] seg4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_bin_display #(.DIGITS(6), .BIN_W(16), .ACTIVE_LOW(1)) dut6 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready6),
    .value_in(value_in), .signed_in(signed_in), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .segments(seg6), .done(done6), .ovf(ovf6));

  seg7_bin_display #(.DIGITS(4), .BIN_W(16), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready4),
    .value_in(value_in), .signed_in(signed_in), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .segments(seg4), .done(done4), .ovf(ovf4));

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h18; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference: digits by repeated division of the integer magnitude.
  function automatic void ref_model(input int nd, input logic [15:0] v,
                                    input logic s, input logic h, input logic b,
                                    output logic [41:0] seg, output logic ov);
    int mag, base, n;
    bit neg;
    int dig[8];
    logic [6:0] g;
    neg  = s && !h && v[15];
    mag  = neg ? (65536 - int'(v)) : int'(v);
    base = h ? 16 : 10;
    n    = 1;
    for (int i = 0; i < 8; i++) begin
      dig[i] = mag % base;
      mag    = mag / base;
      if (dig[i] != 0) n = i + 1;
    end
    ov  = (n + int'(neg)) > nd;
    seg = '1;
    for (int p = 0; p < nd; p++) begin
      if (ov)                                 g = 7'h3F;
      else if (p < n)                         g = glyph(dig[p]);
      else if (neg && p == (b ? n : nd - 1))  g = 7'h3F;
      else if (b)                             g = 7'h7F;
      else                                    g = glyph(0);
      seg[7*p +: 7] = g;
    end
  endfunction

  // Issue one value (caller is at a negedge) and wait for done, bounded.
  // lat = number of posedges after the accept edge until done is seen.
  task automatic send(input logic [15:0] v, input logic s, input logic h,
                      input logic b, input bit noise, output int lat);
    int guard = 0;
    while (ready6 !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    valid_in = 1'b1; value_in = v; signed_in = s; hex_mode = h; blank_lz = b;
    @(negedge clk);
    valid_in = 1'b0;
    lat = 0;
    while (done6 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      valid_in = 1'b0;
      if (noise && done6 !== 1'b1) begin
        valid_in = 1'($urandom_range(0, 1));
        value_in = 16'($urandom);
        hex_mode = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; value_in = '0;
    signed_in = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (seg6 !== {6{7'h7F}}) begin errors++; $display("FAIL reset_seg6 got=%h exp=%h", seg6, {6{7'h7F}}); end
    checks++; if (seg4 !== {4{7'h7F}}) begin errors++; $display("FAIL reset_seg4 got=%h exp=%h", seg4, {4{7'h7F}}); end
    checks++; if (ready6 !== 1'b1 || ready4 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", ready6, ready4); end
    checks++; if (done6 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b%b exp=00", done6, done4); end
    checks++; if (ovf6 !== 1'b0 || ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b%b exp=00", ovf6, ovf4); end
  endtask

  task automatic test_decimal();
    logic [15:0] vv[5]  = '{16'd1234, 16'hFF85, 16'hFF85, 16'h8000, 16'd0};
    logic        ss[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        bb[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [41:0] lit[5] = '{
      {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19},
      {7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h24, 7'h30},
      {7'h3F, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30},
      {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00},
      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    logic [41:0] e6, e4;
    logic        o6, o4;
    int          lat;
    for (int k = 0; k < 5; k++) begin
      send(vv[k], ss[k], 1'b0, bb[k], (k == 0), lat);
      ref_model(6, vv[k], ss[k], 1'b0, bb[k], e6, o6);
      ref_model(4, vv[k], ss[k], 1'b0, bb[k], e4, o4);
      checks++; if (lat !== 17) begin errors++; $display("FAIL dec_latency case=%0d got=%0d exp=17", k, lat); end
      checks++; if (seg6 !== lit[k]) begin errors++; $display("FAIL dec_seg6_lit case=%0d got=%h exp=%h", k, seg6, lit[k]); end
      checks++; if (seg6 !== e6) begin errors++; $display("FAIL dec_seg6_model case=%0d got=%h exp=%h", k, seg6, e6); end
      checks++; if (ovf6 !== 1'b0) begin errors++; $display("FAIL dec_ovf6 case=%0d got=%b exp=0", k, ovf6); end
      checks++; if (seg4 !== e4[27:0] || ovf4 !== o4) begin errors++; $display("FAIL dec_dut4 case=%0d got=%h/%b exp=%h/%b", k, seg4, ovf4, e4[27:0], o4); end
      @(negedge clk);
      checks++; if (done6 !== 1'b0 || ready6 !== 1'b1) begin errors++; $display("FAIL dec_after_done case=%0d done=%b ready=%b exp 0/1", k, done6, ready6); end
    end
  endtask

  task automatic test_overflow();
    int lat;
    send(16'd12345, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    checks++; if (seg4 !== {4{7'h3F}} || ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_12345_dut4 got=%h/%b exp=%h/1", seg4, ovf4, {4{7'h3F}}); end
    checks++; if (seg6 !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12} || ovf6 !== 1'b0) begin errors++; $display("FAIL ovf_12345_dut6 got=%h/%b", seg6, ovf6); end
    @(negedge clk);
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", ovf4); end
    send(16'd7, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    checks++; if (seg4 !== {7'h7F, 7'h7F, 7'h7F, 7'h78} || ovf4 !== 1'b0) begin errors++; $display("FAIL ovf_7_dut4 got=%h/%b exp=%h/0", seg4, ovf4, {7'h7F, 7'h7F, 7'h7F, 7'h78}); end
    @(negedge clk);
  endtask

  task automatic test_hex();
    int lat;
    send(16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hex_latency got=%0d exp=1", lat); end
    checks++; if (seg6 !== {7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E} || ovf6 !== 1'b0) begin errors++; $display("FAIL hex_beef_dut6 got=%h/%b", seg6, ovf6); end
    checks++; if (seg4 !== {7'h03, 7'h06, 7'h06, 7'h0E} || ovf4 !== 1'b0) begin errors++; $display("FAIL hex_beef_dut4 got=%h/%b", seg4, ovf4); end
    checks++; if (ready6 !== 1'b1) begin errors++; $display("FAIL hex_ready_in_done got=%b exp=1", ready6); end
    // Back-to-back: issued in the done cycle; signed_in must be ignored.
    send(16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hex_b2b_latency got=%0d exp=1", lat); end
    checks++; if (seg6 !== {7'h40, 7'h40, 7'h00, 7'h40, 7'h40, 7'h40} || ovf6 !== 1'b0) begin errors++; $display("FAIL hex_8000_dut6 got=%h/%b", seg6, ovf6); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic        s, h, b;
    logic [41:0] e6, e4;
    logic        o6, o4;
    int          lat;
    for (int k = 0; k < 40; k++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      s = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 3) == 0);
      b = 1'($urandom_range(0, 1));
      if (k > 0) begin
        checks++; if (ready6 !== 1'b1 || done4 !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d ready=%b done4=%b exp 1/1", k, ready6, done4); end
      end
      send(v, s, h, b, 1'b0, lat);
      ref_model(6, v, s, h, b, e6, o6);
      ref_model(4, v, s, h, b, e4, o4);
      checks++; if (lat !== (h ? 1 : 17)) begin errors++; $display("FAIL b2b_latency k=%0d got=%0d exp=%0d", k, lat, h ? 1 : 17); end
      checks++; if (seg6 !== e6 || ovf6 !== o6) begin errors++; $display("FAIL b2b_dut6 k=%0d v=%h s=%b h=%b b=%b got=%h/%b exp=%h/%b", k, v, s, h, b, seg6, ovf6, e6, o6); end
      checks++; if (seg4 !== e4[27:0] || ovf4 !== o4) begin errors++; $display("FAIL b2b_dut4 k=%0d v=%h s=%b h=%b b=%b got=%h/%b exp=%h/%b", k, v, s, h, b, seg4, ovf4, e4[27:0], o4); end
    end
    repeat (4) @(negedge clk);
    checks++; if (seg6 !== e6 || done6 !== 1'b0) begin errors++; $display("FAIL b2b_hold got=%h/%b exp=%h/0", seg6, done6, e6); end
  endtask

  task automatic test_reset_midconv();
    int lat;
    int pulses = 0;
    send(16'd12345, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    @(negedge clk);
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL midrst_pre_ovf got=%b exp=1", ovf4); end
    valid_in = 1'b1; value_in = 16'd999; signed_in = 1'b0; hex_mode = 1'b0; blank_lz = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (seg6 !== {6{7'h7F}} || seg4 !== {4{7'h7F}}) begin errors++; $display("FAIL midrst_seg got=%h/%h exp all 7F", seg6, seg4); end
    checks++; if (ready6 !== 1'b1 || ovf4 !== 1'b0 || done6 !== 1'b0) begin errors++; $display("FAIL midrst_ctrl ready=%b ovf4=%b done=%b exp 1/0/0", ready6, ovf4, done6); end
    repeat (25) begin
      @(negedge clk);
      if (done6 === 1'b1 || done4 === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d pulses exp=0", pulses); end
    checks++; if (seg6 !== {6{7'h7F}}) begin errors++; $display("FAIL midrst_hold got=%h exp all 7F", seg6); end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_overflow();
    test_hex();
    test_back_to_back();
    test_reset_midconv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_bin_display.md
Name: seg7_bin_display

Overview:
- Multi-digit 7-segment display driver. Accepts a binary value through a valid/ready handshake, converts it to BCD with a sequential double-dabble engine (or splits it into hex nibbles), and applies leading-zero blanking, a minus sign and overflow indication.
- Outputs registered segment patterns for DIGITS displays.
- Sits between sensor/arithmetic logic (e.g. accelerometer axis values) and the board HEX displays. Generalises the single-digit BCD decoder to N digits, signed/hex modes and blanking.

Parameters:
- DIGITS, 6, number of 7-segment digits driven (2..8).
- BIN_W, 16, width of the binary input (4..24, multiple of 4).
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = all patterns inverted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  value_in/mode inputs valid this cycle.
- ready_out  output  1  block idle, can accept.
- value_in  input  BIN_W  binary value (two's complement when signed_in=1).
- signed_in  input  1  interpret value_in as signed (decimal mode only).
- hex_mode  input  1  1 = display hexadecimal nibbles, 0 = decimal.
- blank_lz  input  1  1 = blank leading zeros.
- segments  output  7*DIGITS  digit i at bits [7i+6:7i], bit order gfedcba, digit 0 rightmost.
- done  output  1  one-cycle pulse when segments updated.
- ovf  output  1  last displayed value did not fit; held until next update.

Behaviour:
- Reset (sync, any state): FSM→IDLE; segments = all blank (7'h7F per digit when ACTIVE_LOW=1); done=0; ovf=0; ready_out=1. A conversion in progress is aborted and nothing is displayed.
- Encoding (ACTIVE_LOW=1, gfedcba):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18.
  - Hex letters: A=08, b=03, C=46, d=21, E=06, F=0E.
  - Special: blank=7F, dash=3F.
  - ACTIVE_LOW=0 inverts every pattern.
- Handshake: ready_out = (state==IDLE). Accept on valid_in & ready_out at edge k: capture the mode bits and the magnitude (|value_in| if signed_in & !hex_mode & MSB set, else value_in) plus a neg flag. valid_in while busy is ignored, not queued.
- States:
  - IDLE → CONV (decimal) or FMT (hex).
  - CONV: BIN_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts magnitude MSB into BCD. The BCD register holds enough nibbles for 2^BIN_W-1.
  - FMT: one cycle. Builds the digit codes and registers segments/ovf.
  - FMT → IDLE.
- Latency:
  - Decimal: segments/ovf update at edge k+BIN_W+1; done=1 during the following cycle.
  - Hex: the same update happens at edge k+1.
  - ready_out is high in the done cycle, so back-to-back accept is allowed there.
- Formatting (decimal):
  - n = count of significant digits; n = 1 for value 0.
  - Required digits = n + neg.
  - If required digits > DIGITS: all digits dash, ovf=1.
  - Otherwise ovf=0. Digits above n show blank (blank_lz=1) or 0 (blank_lz=0).
  - When neg: dash at position n if blank_lz=1, else at position DIGITS-1. If blank_lz=0, neg needs n ≤ DIGITS-1, else overflow.
- Formatting (hex):
  - Nibble i at digit i; signed_in is ignored.
  - Positions ≥ BIN_W/4 are treated as 0.
  - If any nonzero nibble falls at position ≥ DIGITS: overflow (all dash, ovf=1).
  - Leading-zero blanking as in decimal; value 0 shows a single 0.
- Most negative input (e.g. 0x8000, BIN_W=16) has magnitude 32768 and must convert correctly with no sign-extension error.
- segments hold their value between updates; they change only at FMT or reset.

Test Plan (DIGITS=6, BIN_W=16, ACTIVE_LOW=1 unless stated):
- Reset, then idle 5 cycles → segments all 7F, ready_out=1, done=0, ovf=0. Assert rst mid-CONV → segments all 7F next cycle, no done pulse, ready_out=1.
- Unsigned 1234, blank_lz=1, accept at edge k → done pulse after edge k+17. Digits 5..0 = 7F,7F,79,24,30,19. valid_in pulses during CONV are ignored.
- Signed 0xFF85 (-123), blank_lz=1 → 7F,7F,3F,79,24,30. Same with blank_lz=0 → 3F,40,40,79,24,30.
- Signed 0x8000 → 3F,30,24,78,02,00 (-32768), ovf=0. Unsigned 0, blank_lz=1 → 7F×5,40.
- DIGITS=4, unsigned 12345 → all digits 3F, ovf=1. Then unsigned 7 → 7F,7F,7F,78, ovf=0.
- Hex 0xBEEF, blank_lz=1 → 7F,7F,03,06,06,0E, done after edge k+1. Back-to-back accept in the done cycle is honoured.
